tipi_rbus_master: RTL and testbench

Synchronous master for the TIPI register serial bus, the Raspberry-Pi-side neighbour of the TIPI CPLD top level. It accepts byte-wide register commands and generates the `r_clk`, `r_le`, `r_rt`, `r_cd` and `r_dout` sequences that the CPLD shift registers consume. For reads it also captures the serial `r_din` stream.

- Writes transfer a byte into RD or RC.
- Reads fetch TD or TC, the bytes the TI latched.
- It is used in the Pi-side bridge FPGA and as the bus driver in the CPLD system bench.

---
 rtl/tipi_rbus_pkg.sv | 26 ++
 rtl/tipi_rbus_phase.sv | 34 +++
 rtl/tipi_rbus_master.sv | 235 +++++++++++++++++++++++
 tb/tb_tipi_rbus_master.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tipi_rbus_pkg.sv
// Shared types and constants for the TIPI register serial bus master.
package tipi_rbus_pkg;

    // Master sequencing states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD_HI,
        ST_LOAD_LO,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_LATCH_HI,
        ST_LATCH_LO,
        ST_DONE
    } state_e;

    // {rt,cd} register selectors as seen by the CPLD
    localparam logic [1:0] SEL_RC = 2'b00;
    localparam logic [1:0] SEL_RD = 2'b01;
    localparam logic [1:0] SEL_TC = 2'b10;
    localparam logic [1:0] SEL_TD = 2'b11;

    // System clocks per r_clk half phase
    localparam int HALF_PERIOD_DEF = 4;

endpackage

// File: rtl/tipi_rbus_phase.sv
// Half-period timer: counts HALF_PERIOD system clocks from every restart and
// flags the last cycle of the half period with a one-cycle phase_end tick.
module tipi_rbus_phase
    import tipi_rbus_pkg::*;
#(
    parameter int HALF_PERIOD = HALF_PERIOD_DEF
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_restart,
    output logic o_phase_end
);

    localparam logic [7:0] RELOAD = 8'(HALF_PERIOD - 1);

    logic [7:0] r_cnt;
    logic [7:0] w_cnt;

    // A restart counts its own cycle as the first of the half period
    assign w_cnt       = i_restart ? RELOAD : r_cnt;
    assign o_phase_end = (w_cnt == 8'd0);

    // Count down through the half period and rest at zero once it has elapsed
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= 8'd0;
        end else if (o_phase_end) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= w_cnt - 8'd1;
        end
    end

endmodule

// File: rtl/tipi_rbus_master.sv
// TIPI register serial bus master. Turns byte-wide register commands into the
// r_clk / r_le / r_rt / r_cd / r_dout sequences the CPLD shift registers use,
// and captures the serial r_din stream for reads.
// Optional feature macro: TIPI_RBUS_POLL_EN (repeat read frames while the
// received byte equals cmd_data, responding only on the first difference).
module tipi_rbus_master
    import tipi_rbus_pkg::*;
#(
    parameter int HALF_PERIOD = HALF_PERIOD_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_cd,
    input  logic [0:7] cmd_data,
    input  logic       cmd_poll,
    output logic       rsp_valid,
    output logic [0:7] rsp_data,
    output logic       r_clk,
    output logic       r_le,
    output logic       r_rt,
    output logic       r_cd,
    output logic       r_dout,
    input  logic       r_din
);

    state_e     r_state;
    state_e     r_prev_state;
    logic       w_restart;
    logic       w_phase_end;
    logic       r_din_s1;
    logic       r_din_s2;
    logic [0:7] r_data;
    logic [0:7] r_shift;
    logic [0:7] w_byte;
    logic       r_write;
    logic [2:0] r_bit;
    logic       w_poll_rep;
    logic [1:0] w_sel;
    logic       r_ready;
    logic       r_rsp_vld;
    logic [0:7] r_rsp_byte;
    logic       r_sclk;
    logic       r_strobe;
    logic       r_rt_q;
    logic       r_cd_q;
    logic       r_dout_q;

    assign cmd_ready = r_ready;
    assign rsp_valid = r_rsp_vld;
    assign rsp_data  = r_rsp_byte;
    assign r_clk     = r_sclk;
    assign r_le      = r_strobe;
    assign r_rt      = r_rt_q;
    assign r_cd      = r_cd_q;
    assign r_dout    = r_dout_q;

    // Register selector driven onto {rt,cd}: reads come from the TI side
    assign w_sel = cmd_write ? (cmd_cd ? SEL_RD : SEL_RC)
                             : (cmd_cd ? SEL_TD : SEL_TC);

    // Byte as it stands once the current synchronised r_din bit is shifted in
    assign w_byte = {r_shift[1:7], r_din_s2};

    // Every state change restarts the half-period timer
    assign w_restart = (r_state != r_prev_state);

    tipi_rbus_phase #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_phase (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_restart  (w_restart),
        .o_phase_end(w_phase_end)
    );

`ifdef TIPI_RBUS_POLL_EN
    logic r_poll;

    // Remember whether the accepted command is a polling read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_poll <= 1'b0;
        end else if (cmd_valid && r_ready) begin
            r_poll <= cmd_poll & ~cmd_write;
        end
    end

    assign w_poll_rep = r_poll && (w_byte == r_data);
`else
    logic w_unused_poll;
    assign w_unused_poll = cmd_poll;
    assign w_poll_rep    = 1'b0;
`endif

    // Two-flop synchroniser for the asynchronous serial read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_din_s1 <= 1'b0;
            r_din_s2 <= 1'b0;
        end else begin
            r_din_s1 <= r_din;
            r_din_s2 <= r_din_s1;
        end
    end

    // Previous state, used to detect state changes for the phase timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_state <= ST_IDLE;
        end else begin
            r_prev_state <= r_state;
        end
    end

    // Bus sequencer; all bus and handshake outputs are registered here
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b1;
            r_rsp_vld  <= 1'b0;
            r_rsp_byte <= '0;
            r_sclk     <= 1'b0;
            r_strobe   <= 1'b0;
            r_rt_q     <= 1'b0;
            r_cd_q     <= 1'b0;
            r_dout_q   <= 1'b0;
            r_write    <= 1'b0;
            r_data     <= '0;
            r_shift    <= '0;
            r_bit      <= 3'd0;
        end else begin
            r_rsp_vld <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (cmd_valid) begin
                        r_state  <= ST_SETUP;
                        r_ready  <= 1'b0;
                        r_write  <= cmd_write;
                        r_data   <= cmd_data;
                        r_bit    <= 3'd0;
                        {r_rt_q, r_cd_q} <= w_sel;
                        r_dout_q <= cmd_write & cmd_data[0];
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (w_phase_end) begin
                        if (r_write) begin
                            r_state <= ST_SHIFT_HI;
                            r_sclk  <= 1'b1;
                        end else begin
                            r_state  <= ST_LOAD_HI;
                            r_strobe <= 1'b1;
                        end
                    end
                end
                ST_LOAD_HI: begin
                    if (w_phase_end) begin
                        r_state  <= ST_LOAD_LO;
                        r_strobe <= 1'b0;
                    end
                end
                ST_LOAD_LO: begin
                    if (w_phase_end) begin
                        r_state <= ST_SHIFT_HI;
                        r_sclk  <= 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (w_phase_end) begin
                        r_state <= ST_SHIFT_LO;
                        r_sclk  <= 1'b0;
                        // Next write bit goes out as r_clk falls
                        if (r_write && (r_bit != 3'd7)) begin
                            r_dout_q <= r_data[r_bit + 3'd1];
                        end
                    end
                end
                ST_SHIFT_LO: begin
                    if (w_phase_end) begin
                        if (!r_write) begin
                            r_shift <= w_byte;
                        end
                        if (r_bit != 3'd7) begin
                            r_bit   <= r_bit + 3'd1;
                            r_state <= ST_SHIFT_HI;
                            r_sclk  <= 1'b1;
                        end else begin
                            r_bit <= 3'd0;
                            if (r_write) begin
                                r_state  <= ST_LATCH_HI;
                                r_strobe <= 1'b1;
                            end else if (w_poll_rep) begin
                                // Byte still matches: run another full read frame
                                r_state <= ST_SETUP;
                            end else begin
                                r_state    <= ST_DONE;
                                r_rsp_vld  <= 1'b1;
                                r_ready    <= 1'b1;
                                r_rsp_byte <= w_byte;
                                r_rt_q     <= 1'b0;
                                r_cd_q     <= 1'b0;
                                r_dout_q   <= 1'b0;
                            end
                        end
                    end
                end
                ST_LATCH_HI: begin
                    if (w_phase_end) begin
                        r_state  <= ST_LATCH_LO;
                        r_strobe <= 1'b0;
                    end
                end
                ST_LATCH_LO: begin
                    if (w_phase_end) begin
                        r_state   <= ST_DONE;
                        r_rsp_vld <= 1'b1;
                        r_ready   <= 1'b1;
                        r_rt_q    <= 1'b0;
                        r_cd_q    <= 1'b0;
                        r_dout_q  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tipi_rbus_master.sv
// Bench for tipi_rbus_master with a behavioural CPLD register model.
// Build with TIPI_RBUS_POLL_EN defined to exercise polling reads.
module tb_tipi_rbus_master;

    localparam int H   = 2;
    localparam int LAT = 19 * H + 1;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic       cmd_cd    = 1'b0;
    logic       cmd_poll  = 1'b0;
    logic [0:7] cmd_data  = '0;
    logic       r_din     = 1'b0;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [0:7] rsp_data;
    logic       r_clk;
    logic       r_le;
    logic       r_rt;
    logic       r_cd;
    logic       r_dout;

    tipi_rbus_master #(
        .HALF_PERIOD(H)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_cd   (cmd_cd),
        .cmd_data (cmd_data),
        .cmd_poll (cmd_poll),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .r_clk    (r_clk),
        .r_le     (r_le),
        .r_rt     (r_rt),
        .r_cd     (r_cd),
        .r_dout   (r_dout),
        .r_din    (r_din)
    );

    always #5 clk = ~clk;

    // CPLD register model
    logic [7:0] m_rd = 8'h00, m_rc = 8'h00, m_td = 8'h00, m_tc = 8'h00;
    logic [7:0] m_sh = 8'h00, m_out = 8'h00;
    int  sclk_rises = 0, le_rises = 0, rd_loads = 0, le_at_sclk = 0;
    logic le_rt = 1'b0, le_cd = 1'b0;
    bit  dout_bits[$];
    bit  poll_mode = 1'b0;
    int  poll_base = 0;

    int  cyc = 0, accepts = 0, overlap = 0;
    int  n_tests = 0, n_fail = 0;

    typedef struct {
        logic [7:0] data;
        int         lat;
    } exp_t;
    exp_t sb[$];

    always @(posedge r_clk or posedge r_le) begin
        if (r_le) begin
            le_rises   <= le_rises + 1;
            le_rt      <= r_rt;
            le_cd      <= r_cd;
            le_at_sclk <= sclk_rises;
            if (r_rt) begin
                rd_loads <= rd_loads + 1;
                m_out    <= r_cd ? m_td
                          : ((poll_mode && (rd_loads - poll_base >= 3)) ? 8'h5A : m_tc);
            end else if (r_cd) begin
                m_rd <= m_sh;
            end else begin
                m_rc <= m_sh;
            end
        end else begin
            sclk_rises <= sclk_rises + 1;
            if (r_rt) begin
                r_din <= m_out[7];
                m_out <= {m_out[6:0], 1'b0};
            end else begin
                m_sh <= {m_sh[6:0], r_dout};
                dout_bits.push_back(r_dout);
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cmd_valid && cmd_ready) accepts <= accepts + 1;
    end

    always @(negedge clk) begin
        if (r_clk && r_le) overlap <= overlap + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic issue(input bit wr, input bit cd, input logic [7:0] d,
                         input bit poll, output int c0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_cd    = cd;
        cmd_data  = d;
        cmd_poll  = poll;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_poll  = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_rsp(input int c0, input int budget, output logic [7:0] d,
                            output int lat, output bit ok);
        ok  = 1'b0;
        d   = '0;
        lat = 0;
        for (int i = 0; i < budget; i++) begin
            if (rsp_valid) begin
                ok  = 1'b1;
                d   = rsp_data;
                lat = cyc - c0 + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if ({cmd_ready, rsp_valid, r_clk, r_le, r_rt, r_cd, r_dout} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 1000000",
                     {cmd_ready, rsp_valid, r_clk, r_le, r_rt, r_cd, r_dout});
        end
        n_tests++;
        if (rsp_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rsp_data: got %h required 00", rsp_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_rd();
        int c0, lat, b0, s0, l0;
        bit ok;
        logic [7:0] d, bits;
        exp_t e;
        b0 = dout_bits.size();
        s0 = sclk_rises;
        l0 = le_rises;
        issue(1'b1, 1'b1, 8'hA5, 1'b0, c0);
        sb.push_back('{data: 8'h00, lat: LAT});
        wait_rsp(c0, 80, d, lat, ok);
        e = sb.pop_front();
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL write_timeout: got no rsp_valid, required one"); end
        n_tests++;
        if (lat !== e.lat) begin n_fail++; $display("FAIL write_latency: got %0d required %0d", lat, e.lat); end
        n_tests++;
        if (d !== e.data) begin n_fail++; $display("FAIL write_rsp_data_held: got %h required %h", d, e.data); end
        bits = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b0 + i < dout_bits.size()) bits = {bits[6:0], dout_bits[b0 + i]};
        end
        n_tests++;
        if (bits !== 8'hA5 || dout_bits.size() - b0 !== 8) begin
            n_fail++;
            $display("FAIL write_dout_bits: got %h (%0d bits) required a5 (8 bits)", bits, dout_bits.size() - b0);
        end
        n_tests++;
        if (le_rises - l0 !== 1 || le_at_sclk - s0 !== 8) begin
            n_fail++;
            $display("FAIL write_le: got %0d strobes after %0d pulses required 1 after 8", le_rises - l0, le_at_sclk - s0);
        end
        n_tests++;
        if ({le_rt, le_cd} !== 2'b01) begin n_fail++; $display("FAIL write_sel: got %b required 01", {le_rt, le_cd}); end
        n_tests++;
        if (m_rd !== 8'hA5) begin n_fail++; $display("FAIL write_rd_value: got %h required a5", m_rd); end
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL write_rsp_pulse: got %b required 0", rsp_valid); end
    endtask

    task automatic test_read_tc();
        int c0, lat, s0, l0;
        bit ok;
        logic [7:0] d;
        exp_t e;
        m_tc = 8'h3C;
        s0 = sclk_rises;
        l0 = le_rises;
        issue(1'b0, 1'b0, 8'h00, 1'b0, c0);
        sb.push_back('{data: 8'h3C, lat: LAT});
        wait_rsp(c0, 80, d, lat, ok);
        e = sb.pop_front();
        n_tests++;
        if (!ok || d !== e.data) begin n_fail++; $display("FAIL read_tc_data: got %h (ok=%0d) required %h", d, ok, e.data); end
        n_tests++;
        if (lat !== e.lat) begin n_fail++; $display("FAIL read_tc_latency: got %0d required %0d", lat, e.lat); end
        n_tests++;
        if (le_rises - l0 !== 1 || le_at_sclk !== s0) begin
            n_fail++;
            $display("FAIL read_tc_le_order: got %0d strobes after %0d pulses required 1 after 0", le_rises - l0, le_at_sclk - s0);
        end
        n_tests++;
        if ({le_rt, le_cd} !== 2'b10) begin n_fail++; $display("FAIL read_tc_sel: got %b required 10", {le_rt, le_cd}); end
        n_tests++;
        if (sclk_rises - s0 !== 8) begin n_fail++; $display("FAIL read_tc_pulses: got %0d required 8", sclk_rises - s0); end
        @(negedge clk);
        n_tests++;
        if ({r_rt, r_cd, r_dout} !== 3'b000) begin n_fail++; $display("FAIL read_tc_idle_bus: got %b required 000", {r_rt, r_cd, r_dout}); end
    endtask

    task automatic test_back_to_back();
        int c0, c1, lat;
        bit ok;
        logic [7:0] d;
        exp_t e;
        m_td = 8'hFF;
        issue(1'b0, 1'b1, 8'h00, 1'b0, c0);
        sb.push_back('{data: 8'hFF, lat: LAT});
        wait_rsp(c0, 80, d, lat, ok);
        e = sb.pop_front();
        n_tests++;
        if (!ok || d !== e.data || lat !== e.lat) begin
            n_fail++;
            $display("FAIL b2b_read: got %h at %0d required %h at %0d", d, lat, e.data, e.lat);
        end
        n_tests++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_in_done: got %b required 1", cmd_ready); end
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_cd    = 1'b0;
        cmd_data  = 8'h01;
        @(negedge clk);
        cmd_valid = 1'b0;
        c1 = cyc;
        sb.push_back('{data: 8'hFF, lat: LAT});
        wait_rsp(c1, 80, d, lat, ok);
        e = sb.pop_front();
        n_tests++;
        if (!ok || lat !== e.lat) begin n_fail++; $display("FAIL b2b_write_latency: got %0d (ok=%0d) required %0d", lat, ok, e.lat); end
        n_tests++;
        if (d !== e.data) begin n_fail++; $display("FAIL b2b_rsp_data_held: got %h required %h", d, e.data); end
        n_tests++;
        if (m_rc !== 8'h01) begin n_fail++; $display("FAIL b2b_rc_value: got %h required 01", m_rc); end
    endtask

    task automatic test_held_valid();
        int c0, lat, a0;
        bit ok;
        logic [7:0] d;
        exp_t e;
        a0 = accepts;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_cd    = 1'b1;
        cmd_data  = 8'h77;
        @(negedge clk);
        c0 = cyc;
        sb.push_back('{data: 8'hFF, lat: LAT});
        sb.push_back('{data: 8'hFF, lat: 2 * LAT});
        for (int k = 0; k < 2; k++) begin
            if (k == 1) @(negedge clk);
            wait_rsp(c0, 90, d, lat, ok);
            e = sb.pop_front();
            n_tests++;
            if (!ok || lat !== e.lat || d !== e.data) begin
                n_fail++;
                $display("FAIL held_rsp%0d: got %h at %0d (ok=%0d) required %h at %0d", k, d, lat, ok, e.data, e.lat);
            end
        end
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (accepts - a0 !== 2) begin n_fail++; $display("FAIL held_accepts: got %0d required 2", accepts - a0); end
        n_tests++;
        if (m_rd !== 8'h77) begin n_fail++; $display("FAIL held_rd_value: got %h required 77", m_rd); end
    endtask

    task automatic test_poll();
        int c0, lat, r0;
        bit ok;
        logic [7:0] d;
        exp_t e;
        r0 = rd_loads;
`ifdef TIPI_RBUS_POLL_EN
        m_tc      = 8'h00;
        poll_base = rd_loads;
        poll_mode = 1'b1;
        issue(1'b0, 1'b0, 8'h00, 1'b1, c0);
        sb.push_back('{data: 8'h5A, lat: 4 * 19 * H + 1});
        wait_rsp(c0, 300, d, lat, ok);
        e = sb.pop_front();
        n_tests++;
        if (!ok || d !== e.data || lat !== e.lat) begin
            n_fail++;
            $display("FAIL poll_rsp: got %h at %0d (ok=%0d) required %h at %0d", d, lat, ok, e.data, e.lat);
        end
        n_tests++;
        if (rd_loads - r0 !== 4) begin n_fail++; $display("FAIL poll_frames: got %0d required 4", rd_loads - r0); end
        poll_mode = 1'b0;
`else
        m_tc = 8'h42;
        issue(1'b0, 1'b0, 8'h42, 1'b1, c0);
        sb.push_back('{data: 8'h42, lat: LAT});
        wait_rsp(c0, 300, d, lat, ok);
        e = sb.pop_front();
        n_tests++;
        if (!ok || d !== e.data || lat !== e.lat) begin
            n_fail++;
            $display("FAIL poll_ignored_rsp: got %h at %0d (ok=%0d) required %h at %0d", d, lat, ok, e.data, e.lat);
        end
        n_tests++;
        if (rd_loads - r0 !== 1) begin n_fail++; $display("FAIL poll_ignored_frames: got %0d required 1", rd_loads - r0); end
`endif
        @(negedge clk);
        wait_rsp(cyc, 60, d, lat, ok);
        n_tests++;
        if (ok) begin n_fail++; $display("FAIL poll_extra_rsp: got extra rsp_valid, required none"); end
    endtask

    task automatic test_reset_mid_write();
        int c0, s0, l0;
        bit hit;
        logic [7:0] rd_before;
        rd_before = m_rd;
        s0  = sclk_rises;
        l0  = le_rises;
        hit = 1'b0;
        issue(1'b1, 1'b1, 8'h5C, 1'b0, c0);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (sclk_rises - s0 >= 5) begin hit = 1'b1; break; end
        end
        n_tests++;
        if (!hit || r_clk !== 1'b1) begin n_fail++; $display("FAIL rstmid_pulse5: got hit=%0d r_clk=%b required 1 1", hit, r_clk); end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({cmd_ready, rsp_valid, r_clk, r_le, r_rt, r_cd, r_dout} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %b required 1000000",
                     {cmd_ready, rsp_valid, r_clk, r_le, r_rt, r_cd, r_dout});
        end
        n_tests++;
        if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rsp_data: got %h required 00", rsp_data); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (50) @(negedge clk);
        n_tests++;
        if (le_rises !== l0) begin n_fail++; $display("FAIL rstmid_no_le: got %0d strobes required 0", le_rises - l0); end
        n_tests++;
        if (m_rd !== rd_before) begin n_fail++; $display("FAIL rstmid_rd_kept: got %h required %h", m_rd, rd_before); end
        n_tests++;
        if (cmd_ready !== 1'b1 || sclk_rises - s0 !== 5) begin
            n_fail++;
            $display("FAIL rstmid_idle: got ready=%b pulses=%0d required 1 5", cmd_ready, sclk_rises - s0);
        end
    endtask

    initial begin
        test_reset();
        test_write_rd();
        test_read_tc();
        test_back_to_back();
        test_held_valid();
        test_poll();
        test_reset_mid_write();
        n_tests++;
        if (overlap !== 0) begin n_fail++; $display("FAIL le_clk_overlap: got %0d cycles required 0", overlap); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
